dmem_responder: RTL

//  Memory-side responder for the core's load/store port. Accepts one request per handshake,

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory request interface: access sizes,
// responder FSM states and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  // True when the lane offset is not a multiple of the access size.
  function automatic logic size_misaligned(input size_e size, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_H:  mis = lane[0];
      SIZE_W:  mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enable/merge into a word and load
// extract/extend out of a word. Half and word accesses are aligned down.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] old_word,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [1:0]  eff_lane;
  logic [31:0] store_rep;
  logic [15:0] lane_data;

  // Reserved size behaves as a full word.
  always_comb begin
    eff_lane  = 2'b00;
    byte_en   = 4'b1111;
    store_rep = store_data;
    case (size)
      SIZE_B: begin
        eff_lane  = lane;
        byte_en   = 4'b0001 << lane;
        store_rep = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        eff_lane  = {lane[1], 1'b0};
        byte_en   = 4'b0011 << {lane[1], 1'b0};
        store_rep = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = store_rep[8*i +: 8];
    end
  end

  assign lane_data = 16'(old_word >> {eff_lane, 3'b000});

  always_comb begin
    load_data = old_word;
    case (size)
      SIZE_B: load_data = is_unsigned ? {24'h000000, lane_data[7:0]}
                                      : {{24{lane_data[7]}}, lane_data[7:0]};
      SIZE_H: load_data = is_unsigned ? {16'h0000, lane_data}
                                      : {{16{lane_data[15]}}, lane_data};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked load/store responder over an internal word array with fixed latency.
// Optional access-fault checking is built when DMEM_FAULT_CHECK_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two");
  end

  state_e                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  accept, commit, fault;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  size_e                 size_q;
  logic                  unsigned_q;
  logic [31:0]           wdata_q;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      word_idx;
  logic [31:0]           old_word, merged_word, load_data;
  logic [3:0]            byte_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // req_ready is gated by reset so it reads low for the whole reset pulse.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = reset;
        accept    = req_valid && reset;
        if (accept) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        commit = (cnt == '0);
        if (commit) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
    end else if (accept) begin
      cnt        <= CNT_W'(LATENCY - 1);
      we_q       <= req_we;
      addr_q     <= req_addr;
      size_q     <= size_e'(req_size);
      unsigned_q <= req_unsigned;
      wdata_q    <= req_wdata;
    end else if (state == ST_ACCESS && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign word_idx = addr_q[IDX_W+1:2];
  assign old_word = mem[word_idx];

`ifdef DMEM_FAULT_CHECK_EN
  assign fault = size_misaligned(size_q, addr_q[1:0]) ||
                 (size_q == SIZE_RSVD) ||
                 (addr_q[ADDR_WIDTH-1:IDX_W+2] != '0);
`else
  logic unused_high_addr;
  assign unused_high_addr = ^addr_q[ADDR_WIDTH-1:IDX_W+2];
  assign fault            = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .store_data  (wdata_q),
    .old_word    (old_word),
    .byte_en     (byte_en),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // Array has no reset; a store only lands on its commit edge, so a reset
  // during ACCESS drops it.
  always_ff @(posedge clk) begin
    if (commit && we_q && !fault) mem[word_idx] <= merged_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= fault;
      rsp_rdata <= (we_q || fault) ? 32'h0 : load_data;
    end
  end

endmodule
